// File: rtl/rc4_key_search_ctrl.sv
// rc4_key_search_ctrl: top-level sequencer for the RC4 brute-force key search.
// For each candidate key it runs S-array init, the key schedule and the
// decrypt pass in turn. It owns the single S-RAM port and checks every
// plaintext byte. A candidate key is rejected on its first non-printable byte.
// The search stops on a full printable message or when the key range is used up.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   go                             level start request (sampled in IDLE)
//   init/ksa/dec_start             one-cycle start pulses to the sub-FSMs
//   init/ksa/dec_done              level done flags from the sub-FSMs
//   sub_reset_n                    one-cycle active-low sub-FSM reset per key change
//   init/ksa/dec_addr/data/wren    per-phase S-RAM requests
//   s_addr, s_data, s_wren         muxed S-RAM port
//   dec_wr_valid, dec_wr_data      plaintext byte being written by decrypt
//   secret_key                     current candidate key
//   busy, key_found, exhausted     status decodes of the sequencer state
//
// Build option: define RC4_KEY_STRIDE_EN to add KEY_START / KEY_STRIDE so the
// key space can be split across parallel cores. When the macro is undefined,
// the search starts at key 0 and steps by 1.
module rc4_key_search_ctrl #(
    parameter logic [23:0] KEY_MAX = 24'h3FFFFF,
    parameter int unsigned MSG_LEN = 32
`ifdef RC4_KEY_STRIDE_EN
    ,
    parameter logic [23:0] KEY_START  = 24'd0,
    parameter logic [23:0] KEY_STRIDE = 24'd1
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    output logic        init_start,
    output logic        ksa_start,
    output logic        dec_start,
    input  logic        init_done,
    input  logic        ksa_done,
    input  logic        dec_done,
    output logic        sub_reset_n,
    input  logic [7:0]  init_addr,
    input  logic [7:0]  ksa_addr,
    input  logic [7:0]  dec_addr,
    input  logic [7:0]  init_data,
    input  logic [7:0]  ksa_data,
    input  logic [7:0]  dec_data,
    input  logic        init_wren,
    input  logic        ksa_wren,
    input  logic        dec_wren,
    output logic [7:0]  s_addr,
    output logic [7:0]  s_data,
    output logic        s_wren,
    input  logic        dec_wr_valid,
    input  logic [7:0]  dec_wr_data,
    output logic [23:0] secret_key,
    output logic        busy,
    output logic        key_found,
    output logic        exhausted
);

`ifdef RC4_KEY_STRIDE_EN
    localparam logic [23:0] KEY_BASE = KEY_START;
    localparam logic [23:0] KEY_STEP = KEY_STRIDE;
`else
    localparam logic [23:0] KEY_BASE = 24'd0;
    localparam logic [23:0] KEY_STEP = 24'd1;
`endif

    localparam int unsigned CNT_W = $clog2(MSG_LEN + 1);
    localparam logic [CNT_W-1:0] MSG_LEN_C = CNT_W'(MSG_LEN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT_RUN,
        ST_KSA_RUN,
        ST_DEC_RUN,
        ST_KEY_NEXT,
        ST_FOUND,
        ST_FAIL
    } state_t;

    state_t           state_q, state_d;
    logic [23:0]      key_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             init_start_d, ksa_start_d, dec_start_d;
    logic             sub_reset_n_d;
    logic             busy_d, key_found_d, exhausted_d;

    // Key step evaluated in 25 bits so a step past KEY_MAX never wraps.
    logic [24:0] key_sum;
    logic        key_last;
    logic        byte_ok;
    logic        byte_bad;

    assign key_sum  = {1'b0, secret_key} + {1'b0, KEY_STEP};
    assign key_last = (key_sum > {1'b0, KEY_MAX});
    assign byte_ok  = (dec_wr_data == 8'd32) ||
                      ((dec_wr_data >= 8'd97) && (dec_wr_data <= 8'd122));
    assign byte_bad = dec_wr_valid && !byte_ok;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            secret_key  <= KEY_BASE;
            cnt_q       <= '0;
            init_start  <= 1'b0;
            ksa_start   <= 1'b0;
            dec_start   <= 1'b0;
            sub_reset_n <= 1'b1;
            busy        <= 1'b0;
            key_found   <= 1'b0;
            exhausted   <= 1'b0;
        end else begin
            state_q     <= state_d;
            secret_key  <= key_d;
            cnt_q       <= cnt_d;
            init_start  <= init_start_d;
            ksa_start   <= ksa_start_d;
            dec_start   <= dec_start_d;
            sub_reset_n <= sub_reset_n_d;
            busy        <= busy_d;
            key_found   <= key_found_d;
            exhausted   <= exhausted_d;
        end
    end

    // Next-state logic. A start pulse is raised on entry to each run state; the
    // pulse being high marks that state's first cycle, in which a done flag left
    // over from the previous key is ignored.
    always_comb begin
        state_d       = state_q;
        key_d         = secret_key;
        cnt_d         = cnt_q;
        init_start_d  = 1'b0;
        ksa_start_d   = 1'b0;
        dec_start_d   = 1'b0;
        sub_reset_n_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (go) begin
                    state_d      = ST_INIT_RUN;
                    init_start_d = 1'b1;
                end
            end
            ST_INIT_RUN: begin
                if (!init_start && init_done) begin
                    state_d     = ST_KSA_RUN;
                    ksa_start_d = 1'b1;
                end
            end
            ST_KSA_RUN: begin
                if (!ksa_start && ksa_done) begin
                    state_d     = ST_DEC_RUN;
                    dec_start_d = 1'b1;
                end
            end
            ST_DEC_RUN: begin
                if (dec_wr_valid && byte_ok && (cnt_q != MSG_LEN_C)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // A bad byte wins over a simultaneous done. The sub-FSM reset is
                // pulsed during KEY_NEXT only when another key will be tried.
                if (byte_bad) begin
                    state_d       = ST_KEY_NEXT;
                    sub_reset_n_d = key_last;
                end else if (!dec_start && dec_done) begin
                    if (cnt_d == MSG_LEN_C) begin
                        state_d = ST_FOUND;
                    end else begin
                        state_d       = ST_KEY_NEXT;
                        sub_reset_n_d = key_last;
                    end
                end
            end
            ST_KEY_NEXT: begin
                if (key_last) begin
                    state_d = ST_FAIL;
                end else begin
                    key_d        = key_sum[23:0];
                    cnt_d        = '0;
                    state_d      = ST_INIT_RUN;
                    init_start_d = 1'b1;
                end
            end
            ST_FOUND: state_d = ST_FOUND;
            ST_FAIL:  state_d = ST_FAIL;
            default:  state_d = ST_IDLE;
        endcase

        busy_d      = (state_d != ST_IDLE) && (state_d != ST_FOUND) && (state_d != ST_FAIL);
        key_found_d = (state_d == ST_FOUND);
        exhausted_d = (state_d == ST_FAIL);
    end

    // S-RAM port goes to the active phase only; idle when no phase owns it.
    always_comb begin
        s_addr = 8'd0;
        s_data = 8'd0;
        s_wren = 1'b0;
        case (state_q)
            ST_INIT_RUN: begin
                s_addr = init_addr;
                s_data = init_data;
                s_wren = init_wren;
            end
            ST_KSA_RUN: begin
                s_addr = ksa_addr;
                s_data = ksa_data;
                s_wren = ksa_wren;
            end
            ST_DEC_RUN: begin
                s_addr = dec_addr;
                s_data = dec_data;
                s_wren = dec_wren;
            end
            default: begin
                s_addr = 8'd0;
                s_data = 8'd0;
                s_wren = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Testbench for rc4_key_search_ctrl. Stub sub-FSMs respond to the start pulses.
// Each candidate key is given a plaintext plan. A reference model walks the
// key sequence over those plans and predicts the found key or exhaustion.
module tb_rc4_key_search_ctrl;

`ifdef RC4_KEY_STRIDE_EN
    localparam logic [23:0] T_KEY_MAX = 24'd14;
    localparam logic [23:0] T_BASE    = 24'd2;
    localparam logic [23:0] T_STEP    = 24'd4;
`else
    localparam logic [23:0] T_KEY_MAX = 24'd3;
    localparam logic [23:0] T_BASE    = 24'd0;
    localparam logic [23:0] T_STEP    = 24'd1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic        init_start, ksa_start, dec_start;
    logic        init_done = 1'b0, ksa_done = 1'b0, dec_done = 1'b0;
    logic        sub_reset_n;
    logic [7:0]  init_addr = 8'd0, ksa_addr = 8'd0, dec_addr = 8'd0;
    logic [7:0]  init_data = 8'd0, ksa_data = 8'd0, dec_data = 8'd0;
    logic        init_wren = 1'b0, ksa_wren = 1'b0, dec_wren = 1'b0;
    logic [7:0]  s_addr, s_data;
    logic        s_wren;
    logic        dec_wr_valid = 1'b0;
    logic [7:0]  dec_wr_data = 8'd0;
    logic [23:0] secret_key;
    logic        busy, key_found, exhausted;

    rc4_key_search_ctrl #(
        .KEY_MAX    (T_KEY_MAX),
        .MSG_LEN    (32)
`ifdef RC4_KEY_STRIDE_EN
        ,
        .KEY_START  (T_BASE),
        .KEY_STRIDE (T_STEP)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .go           (go),
        .init_start   (init_start),
        .ksa_start    (ksa_start),
        .dec_start    (dec_start),
        .init_done    (init_done),
        .ksa_done     (ksa_done),
        .dec_done     (dec_done),
        .sub_reset_n  (sub_reset_n),
        .init_addr    (init_addr),
        .ksa_addr     (ksa_addr),
        .dec_addr     (dec_addr),
        .init_data    (init_data),
        .ksa_data     (ksa_data),
        .dec_data     (dec_data),
        .init_wren    (init_wren),
        .ksa_wren     (ksa_wren),
        .dec_wren     (dec_wren),
        .s_addr       (s_addr),
        .s_data       (s_data),
        .s_wren       (s_wren),
        .dec_wr_valid (dec_wr_valid),
        .dec_wr_data  (dec_wr_data),
        .secret_key   (secret_key),
        .busy         (busy),
        .key_found    (key_found),
        .exhausted    (exhausted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-key plaintext plans, indexed by position in the key sequence.
    logic [7:0] plan_bytes [8][32];
    int         plan_n     [8];
    bit         plan_last  [8];
    bit         force_wren = 1'b0;

    function automatic bit printable(input logic [7:0] b);
        return (b == 8'd32) || (b >= 8'd97 && b <= 8'd122);
    endfunction

    function automatic logic [7:0] rand_ok();
        int r = int'($urandom % 27);
        return (r == 26) ? 8'd32 : 8'(97 + r);
    endfunction

    function automatic logic [7:0] rand_bad();
        logic [7:0] b;
        do b = 8'($urandom); while (printable(b));
        return b;
    endfunction

    // kind 0: full printable message, 1: one bad byte, 2: short message
    task automatic plan_fill(input int idx, input int kind);
        for (int j = 0; j < 32; j++) plan_bytes[idx][j] = rand_ok();
        plan_n[idx]    = 32;
        plan_last[idx] = 1'b0;
        if (kind == 1) begin
            plan_n[idx] = int'($urandom_range(1, 32));
            plan_bytes[idx][int'($urandom_range(0, plan_n[idx] - 1))] = rand_bad();
            plan_last[idx] = 1'($urandom % 2);
        end else if (kind == 2) begin
            plan_n[idx] = int'($urandom_range(1, 31));
        end
    endtask

    // ---------------- stub sub-FSMs ----------------
    bit i_rst, i_go, k_rst, k_go, d_rst, d_go;
    int i_cnt = 0, k_cnt = 0;
    bit d_active = 1'b0;
    int d_pos = 0, d_idx = 0;
    logic [23:0] d_key;

    always begin
        @(negedge clk);
        i_rst = reset || !sub_reset_n;
        i_go  = init_start;
        @(posedge clk);
        #1;
        init_addr = 8'($urandom);
        init_data = 8'($urandom);
        init_wren = 1'($urandom);
        if (i_rst) begin
            i_cnt = 0;
            init_done = 1'b0;
        end else if (i_go) begin
            i_cnt = int'($urandom_range(1, 6));
        end else if (i_cnt > 0) begin
            i_cnt--;
            if (i_cnt == 0) init_done = 1'b1;
        end
    end

    always begin
        @(negedge clk);
        k_rst = reset || !sub_reset_n;
        k_go  = ksa_start;
        @(posedge clk);
        #1;
        ksa_addr = 8'($urandom);
        ksa_data = 8'($urandom);
        ksa_wren = force_wren ? 1'b1 : 1'($urandom);
        if (k_rst) begin
            k_cnt = 0;
            ksa_done = 1'b0;
        end else if (k_go) begin
            k_cnt = int'($urandom_range(1, 6));
        end else if (k_cnt > 0) begin
            k_cnt--;
            if (k_cnt == 0) ksa_done = 1'b1;
        end
    end

    always begin
        @(negedge clk);
        d_rst = reset || !sub_reset_n;
        d_go  = dec_start;
        d_key = secret_key;
        @(posedge clk);
        #1;
        dec_addr     = 8'($urandom);
        dec_data     = 8'($urandom);
        dec_wren     = force_wren ? 1'b1 : 1'($urandom);
        dec_wr_valid = 1'b0;
        dec_wr_data  = 8'($urandom);
        if (d_rst) begin
            d_active = 1'b0;
            dec_done = 1'b0;
        end else if (d_go) begin
            d_active = 1'b1;
            d_pos    = 0;
            d_idx    = int'((d_key - T_BASE) / T_STEP);
            if (d_idx > 7) d_idx = 7;
        end else if (d_active) begin
            if (d_pos < plan_n[d_idx]) begin
                if ($urandom % 4 != 0) begin
                    dec_wr_valid = 1'b1;
                    dec_wr_data  = plan_bytes[d_idx][d_pos];
                    d_pos++;
                    if (d_pos == plan_n[d_idx] && plan_last[d_idx]) begin
                        dec_done = 1'b1;
                        d_active = 1'b0;
                    end
                end
            end else begin
                dec_done = 1'b1;
                d_active = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    int n_init, n_ksa, n_dec, n_srlow, n_srfall, order_err, last_p;
    bit srn_prev = 1'b1, idone_prev = 1'b0, kdone_prev = 1'b0, exp_ksa = 1'b0, exp_dec = 1'b0;
    logic [23:0] key_log [$];

    always @(negedge clk) begin
        if (reset) begin
            n_init = 0; n_ksa = 0; n_dec = 0; n_srlow = 0; n_srfall = 0;
            order_err = 0; last_p = 0; exp_ksa = 1'b0; exp_dec = 1'b0;
            key_log.delete();
        end else begin
            if (exp_ksa) check("done_to_ksa_start", 32'(ksa_start), 32'd1);
            if (exp_dec) check("done_to_dec_start", 32'(dec_start), 32'd1);
            exp_ksa = init_done && !idone_prev;
            exp_dec = ksa_done && !kdone_prev;
            if (init_start) begin
                n_init++;
                if (last_p != 0 && last_p != 3) order_err++;
                last_p = 1;
                key_log.push_back(secret_key);
                check("mux_init_addr", 32'(s_addr), 32'(init_addr));
                check("mux_init_data", 32'(s_data), 32'(init_data));
                check("mux_init_wren", 32'(s_wren), 32'(init_wren));
            end
            if (ksa_start) begin
                n_ksa++;
                if (last_p != 1) order_err++;
                last_p = 2;
                check("mux_ksa_wren", 32'(s_wren), 32'(ksa_wren));
                check("mux_ksa_addr", 32'(s_addr), 32'(ksa_addr));
            end
            if (dec_start) begin
                n_dec++;
                if (last_p != 2) order_err++;
                last_p = 3;
                check("mux_dec_wren", 32'(s_wren), 32'(dec_wren));
                check("mux_dec_data", 32'(s_data), 32'(dec_data));
            end
            if (!sub_reset_n) begin
                n_srlow++;
                if (srn_prev) n_srfall++;
                check("key_next_port_idle", {15'd0, s_wren, s_addr, s_data}, 32'd0);
            end
        end
        srn_prev   = sub_reset_n;
        idone_prev = init_done;
        kdone_prev = ksa_done;
    end

    // ---------------- reference model ----------------
    logic [23:0] m_keys [$];
    bit          m_found;

    function automatic bit plan_good(input int idx);
        if (plan_n[idx] != 32) return 1'b0;
        for (int j = 0; j < 32; j++)
            if (!printable(plan_bytes[idx][j])) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_run();
        logic [24:0] k = {1'b0, T_BASE};
        m_keys.delete();
        m_found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_keys.push_back(k[23:0]);
            if (plan_good(i)) begin
                m_found = 1'b1;
                break;
            end
            if (k + 25'(T_STEP) > 25'(T_KEY_MAX)) break;
            k = k + 25'(T_STEP);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        go    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic run_search(input string tag);
        int tried;
        bit done_seen = 1'b0;
        model_run();
        tried = m_keys.size();
        do_reset();
        go = 1'b1;
        tick();
        @(negedge clk);
        check({tag, "_go_latency"}, 32'(init_start), 32'd1);
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (key_found || exhausted) begin
                done_seen = 1'b1;
                break;
            end
        end
        check({tag, "_terminated"}, 32'(done_seen), 32'd1);
        repeat (12) tick();
        @(negedge clk);
        check({tag, "_key_found"}, 32'(key_found), 32'(m_found));
        check({tag, "_exhausted"}, 32'(exhausted), 32'(!m_found));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_secret_key"}, 32'(secret_key), 32'(m_keys[$]));
        check({tag, "_n_init"}, 32'(n_init), 32'(tried));
        check({tag, "_n_ksa"}, 32'(n_ksa), 32'(tried));
        check({tag, "_n_dec"}, 32'(n_dec), 32'(tried));
        check({tag, "_subrst_cycles"}, 32'(n_srlow), 32'(tried - 1));
        check({tag, "_subrst_pulses"}, 32'(n_srfall), 32'(tried - 1));
        check({tag, "_order"}, 32'(order_err), 32'd0);
        if (key_log.size() == tried) begin
            for (int i = 0; i < tried; i++)
                check({tag, "_key_seq"}, 32'(key_log[i]), 32'(m_keys[i]));
        end else begin
            check({tag, "_key_log_len"}, 32'(key_log.size()), 32'(tried));
        end
        go = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        do_reset();
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", {30'd0, key_found, exhausted}, 32'd0);
        check("rst_starts", {29'd0, init_start, ksa_start, dec_start}, 32'd0);
        check("rst_sub_reset_n", 32'(sub_reset_n), 32'd1);
        check("rst_secret_key", 32'(secret_key), 32'(T_BASE));
        check("rst_port", {15'd0, s_wren, s_addr, s_data}, 32'd0);

        // Sequencing: first key good, all 'a'; other phases always request writes.
        force_wren = 1'b1;
        for (int k = 0; k < 8; k++) plan_fill(k, 0);
        for (int j = 0; j < 32; j++) plan_bytes[0][j] = 8'h61;
        run_search("seq");
        force_wren = 1'b0;

        // Bad third byte on the first key.
        for (int k = 0; k < 8; k++) plan_fill(k, 0);
        plan_bytes[0][2] = 8'h41;
        run_search("bad3");

        // Bad last byte coinciding with done.
        for (int k = 0; k < 8; k++) plan_fill(k, 0);
        plan_bytes[0][31] = 8'h7B;
        plan_last[0] = 1'b1;
        run_search("bad_with_done");

        // Every key fails on its first byte.
        for (int k = 0; k < 8; k++) begin
            plan_fill(k, 0);
            plan_bytes[k][0] = rand_bad();
        end
        run_search("exhaust");

        // Reset in the middle of the second key's KSA phase.
        for (int k = 0; k < 8; k++) plan_fill(k, 0);
        plan_bytes[0][0] = 8'h00;
        do_reset();
        go = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            tick();
            if (n_ksa == 2) begin
                seen = 1'b1;
                break;
            end
        end
        check("mid_ksa_reached", 32'(seen), 32'd1);
        tick();
        check("mid_ksa_key", 32'(secret_key), 32'(T_BASE + T_STEP));
        go    = 1'b0;
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_flags", {30'd0, key_found, exhausted}, 32'd0);
        check("mid_rst_starts", {29'd0, init_start, ksa_start, dec_start}, 32'd0);
        check("mid_rst_sub_reset_n", 32'(sub_reset_n), 32'd1);
        check("mid_rst_secret_key", 32'(secret_key), 32'(T_BASE));
        check("mid_rst_port", {15'd0, s_wren, s_addr, s_data}, 32'd0);
        reset = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("mid_rst_idle", {31'd0, busy}, 32'd0);

        // Random plans.
        for (int r = 0; r < 24; r++) begin
            for (int k = 0; k < 8; k++) begin
                int sel = int'($urandom % 4);
                plan_fill(k, (sel == 0) ? 0 : ((sel == 3) ? 2 : 1));
            end
            run_search("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
